// File: rtl/multdiv_controller.sv
// ---------------------------------------------------------------------------
// multdiv_controller
//
// Sequences a multi-cycle multiply/divide unit from the DX stage of a simple
// pipeline.
//
// Operation:
//   - Recognises MULT/DIV in DX and freezes FD/DX with stall.
//   - Fires a one-cycle start pulse at the unit.
//   - Waits for md_ready, or gives up after TIMEOUT wait cycles.
//   - Performs a single register-file write-back.
//   - An overflow, divide-by-zero or timeout becomes an exception write of a
//     cause code (4 = mult, 5 = div) into r30.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   dx_op, dx_aluop     opcode / ALU opcode of the DX instruction
//   dx_rd               destination register of the DX instruction
//   flush               pipeline flush, aborts an operation still waiting
//   md_result, md_ready,
//   md_ovf              result, ready strobe and error flag from the unit
//   ctrl_MULT, ctrl_DIV one-cycle start pulses to the unit
//   stall               freezes FD and DX
//   busy                controller is not idle
//   wb_valid, wb_rd,
//   wb_data             register-file write port
//   md_exc              exception strobe, coincident with wb_valid
// ---------------------------------------------------------------------------
module multdiv_controller #(
  parameter int TIMEOUT = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  dx_op,
  input  logic [4:0]  dx_aluop,
  input  logic [4:0]  dx_rd,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_ready,
  input  logic        md_ovf,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        md_exc
);

  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [4:0] EXC_RD   = 5'd30;

  // The counter holds (wait cycles already spent - 1).
  // Hitting CNT_LAST therefore marks the TIMEOUT-th wait cycle.
  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d;       // latched kind: 1 = divide, 0 = multiply
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  wb_rd_hold_q, wb_rd_hold_d;
  logic [31:0] wb_data_hold_q, wb_data_hold_d;

  logic        is_mult, is_div, is_md;
  logic [4:0]  wb_rd_calc;
  logic [31:0] wb_data_calc;

  assign is_mult = (dx_op == OP_ALU) && (dx_aluop == ALU_MULT);
  assign is_div  = (dx_op == OP_ALU) && (dx_aluop == ALU_DIV);
  assign is_md   = is_mult | is_div;

  // Write-back payload presented in DONE; an error redirects to r30 with a
  // cause code instead of the result.
  assign wb_rd_calc   = ovf_q ? EXC_RD : rd_q;
  assign wb_data_calc = ovf_q ? (div_q ? 32'd5 : 32'd4) : res_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_d           = rd_q;
    div_d          = div_q;
    res_d          = res_q;
    ovf_d          = ovf_q;
    wb_rd_hold_d   = wb_rd_hold_q;
    wb_data_hold_d = wb_data_hold_q;

    case (state_q)
      S_IDLE: begin
        if (is_md && !flush) begin
          rd_d    = dx_rd;
          div_d   = is_div;
          state_d = S_START;
        end
      end

      S_START: begin
        // md_ready is deliberately ignored here; the unit has only just been
        // started.
        cnt_d   = 6'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q + 6'd1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (md_ready) begin
          res_d   = md_result;
          ovf_d   = md_ovf;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Flush cannot cancel this cycle: the DX instruction retires now.
        wb_rd_hold_d   = wb_rd_calc;
        wb_data_hold_d = wb_data_calc;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 6'd0;
      rd_q           <= 5'd0;
      div_q          <= 1'b0;
      res_q          <= 32'd0;
      ovf_q          <= 1'b0;
      wb_rd_hold_q   <= 5'd0;
      wb_data_hold_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_q           <= rd_d;
      div_q          <= div_d;
      res_q          <= res_d;
      ovf_q          <= ovf_d;
      wb_rd_hold_q   <= wb_rd_hold_d;
      wb_data_hold_q <= wb_data_hold_d;
    end
  end

  // Everything except stall depends on registered state only.
  assign busy      = (state_q != S_IDLE);
  assign ctrl_MULT = (state_q == S_START) && !div_q;
  assign ctrl_DIV  = (state_q == S_START) &&  div_q;
  // A result destined for r0 is dropped; exceptions always write r30.
  assign wb_valid  = (state_q == S_DONE) && (ovf_q || (rd_q != 5'd0));
  assign md_exc    = (state_q == S_DONE) && ovf_q;
  assign wb_rd     = (state_q == S_DONE) ? wb_rd_calc   : wb_rd_hold_q;
  assign wb_data   = (state_q == S_DONE) ? wb_data_calc : wb_data_hold_q;

  // Stall already in the acceptance cycle so DX holds the instruction.
  // Release in DONE so the instruction retires.
  assign stall = ((state_q == S_IDLE) && is_md && !flush)
               || (state_q == S_START) || (state_q == S_WAIT);

endmodule

// File: tb/tb_multdiv_controller.sv
module tb_multdiv_controller;

  localparam int TO = 63;

  logic        clock;
  logic        reset;
  logic [4:0]  dx_op, dx_aluop, dx_rd;
  logic        flush;
  logic [31:0] md_result;
  logic        md_ready, md_ovf;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, wb_valid, md_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  multdiv_controller #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .dx_op(dx_op), .dx_aluop(dx_aluop), .dx_rd(dx_rd),
    .flush(flush),
    .md_result(md_result), .md_ready(md_ready), .md_ovf(md_ovf),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .stall(stall), .busy(busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_exc(md_exc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Operation-level view:
  //   m_age   -1 when no operation is held.
  //           0 in the start-pulse cycle.
  //           n in the n-th wait cycle.
  //   m_done  marks the write-back cycle.
  int          m_age = -1;
  bit          m_done = 1'b0;
  logic [4:0]  m_rd = '0;
  bit          m_div = 1'b0;
  logic [31:0] m_res = '0;
  bit          m_ovf = 1'b0;
  logic [4:0]  m_hold_rd = '0;
  logic [31:0] m_hold_data = '0;

  function automatic bit dx_is_md();
    return (dx_op == 5'd0) && (dx_aluop == 5'd6 || dx_aluop == 5'd7);
  endfunction

  function automatic logic [4:0] m_out_rd();
    return m_ovf ? 5'd30 : m_rd;
  endfunction

  function automatic logic [31:0] m_out_data();
    return m_ovf ? (m_div ? 32'd5 : 32'd4) : m_res;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_age = -1; m_done = 0; m_rd = '0; m_div = 0; m_res = '0; m_ovf = 0;
        m_hold_rd = '0; m_hold_data = '0;
      end else if (m_done) begin
        m_hold_rd   = m_out_rd();
        m_hold_data = m_out_data();
        m_done = 0;
        m_age  = -1;
      end else if (m_age < 0) begin
        if (dx_is_md() && !flush) begin
          m_age = 0;
          m_rd  = dx_rd;
          m_div = (dx_aluop == 5'd7);
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else begin
        if (flush) m_age = -1;
        else if (md_ready) begin
          m_done = 1; m_res = md_result; m_ovf = md_ovf;
        end else if (m_age == TO) begin
          m_done = 1; m_ovf = 1;
        end else m_age++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("busy",      busy,      (m_age >= 0) || m_done);
        chk("ctrl_MULT", ctrl_MULT, (m_age == 0) && !m_done && !m_div);
        chk("ctrl_DIV",  ctrl_DIV,  (m_age == 0) && !m_done &&  m_div);
        chk("wb_valid",  wb_valid,  m_done && (m_ovf || m_rd != 5'd0));
        chk("md_exc",    md_exc,    m_done && m_ovf);
        chk("wb_rd",     wb_rd,     m_done ? m_out_rd()   : m_hold_rd);
        chk("wb_data",   wb_data,   m_done ? m_out_data() : m_hold_data);
        chk("stall",     stall,     ((m_age < 0) && dx_is_md() && !flush) ||
                                    ((m_age >= 0) && !m_done));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int          st_cm, st_cd, st_wb, st_exc, st_stall, done_k;
  logic [4:0]  cap_rd;
  logic [31:0] cap_data;
  bit          busy_hist [0:127];
  bit          stall_hist[0:127];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_nop();
    dx_op = 5'd0; dx_aluop = 5'd0; dx_rd = 5'd0;
  endtask

  // Cycle k=0 presents the instruction. md_ready/flush/reset are pulsed at
  // the given k (-1 = never). The instruction is withdrawn once it retires or
  // is aborted.
  task automatic run_op(input bit div, input logic [4:0] rd, input int ready_k,
                        input logic [31:0] res, input bit ovf, input int flush_k,
                        input int reset_k, input int ncyc);
    bit dx_on = 1'b1;
    st_cm = 0; st_cd = 0; st_wb = 0; st_exc = 0; st_stall = 0; done_k = -1;
    cap_rd = 'x; cap_data = 'x;
    for (int k = 0; k < ncyc; k++) begin
      if (dx_on) begin
        dx_op = 5'd0; dx_aluop = div ? 5'd7 : 5'd6; dx_rd = rd;
      end else set_nop();
      md_ready  = (k == ready_k);
      md_ovf    = ovf && (k == ready_k);
      md_result = (k == ready_k) ? res : 32'hDEAD_BEEF;
      flush     = (k == flush_k);
      reset     = (k == reset_k);
      @(negedge clock);
      if (ctrl_MULT) st_cm++;
      if (ctrl_DIV)  st_cd++;
      if (wb_valid) begin st_wb++; cap_rd = wb_rd; cap_data = wb_data; end
      if (md_exc)    st_exc++;
      if (stall)     st_stall++;
      busy_hist[k]  = busy;
      stall_hist[k] = stall;
      if (busy && !stall && done_k < 0) begin
        done_k = k; dx_on = 1'b0;
        if (!wb_valid) begin cap_rd = wb_rd; cap_data = wb_data; end
      end
      if (k == flush_k || k == reset_k) dx_on = 1'b0;
      tick();
    end
    set_nop();
    md_ready = 0; md_ovf = 0; flush = 0; reset = 0;
  endtask

  initial begin
    set_nop();
    flush = 0; md_ready = 0; md_ovf = 0; md_result = '0;
    reset = 1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 0;
    @(negedge clock);
    chk("rst_busy",    busy,    1'b0);
    chk("rst_wb_rd",   wb_rd,   5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_stall",   stall,   1'b0);
    tick();

    // Mult normal: ready 4 cycles after the pulse.
    run_op(0, 5'd5, 5, 32'h42, 0, -1, -1, 9);
    chk("A_pulses",  st_cm,    1);
    chk("A_div",     st_cd,    0);
    chk("A_wb",      st_wb,    1);
    chk("A_rd",      cap_rd,   5'd5);
    chk("A_data",    cap_data, 32'h42);
    chk("A_exc",     st_exc,   0);
    chk("A_stall",   st_stall, 6);
    chk("A_done_k",  done_k,   6);

    // Div with overflow.
    run_op(1, 5'd7, 3, 32'h1111, 1, -1, -1, 7);
    chk("B_pulses",  st_cd,    1);
    chk("B_rd",      cap_rd,   5'd30);
    chk("B_data",    cap_data, 32'd5);
    chk("B_exc",     st_exc,   1);
    chk("B_wb",      st_wb,    1);

    // Flush and ready in the same wait cycle.
    run_op(0, 5'd3, 4, 32'h99, 0, 4, -1, 8);
    chk("C_wb",      st_wb,        0);
    chk("C_idle",    busy_hist[5], 1'b0);

    // Mult timeout.
    run_op(0, 5'd9, -1, 32'h0, 0, -1, -1, 68);
    chk("D_done_k",  done_k,   65);
    chk("D_rd",      cap_rd,   5'd30);
    chk("D_data",    cap_data, 32'd4);
    chk("D_exc",     st_exc,   1);

    // rd = 0: no write, still completes.
    run_op(0, 5'd0, 5, 32'h55, 0, -1, -1, 9);
    chk("E_wb",      st_wb,        0);
    chk("E_done_k",  done_k,       6);
    chk("E_idle",    busy_hist[7], 1'b0);

    // Reset in the second wait cycle, then a normal mult.
    run_op(0, 5'd12, -1, 32'h0, 0, -1, 3, 7);
    chk("F_busy",    busy_hist[4],  1'b0);
    chk("F_stall",   stall_hist[4], 1'b0);
    chk("F_wb",      st_wb,         0);
    run_op(0, 5'd9, 4, 32'h1234, 0, -1, -1, 8);
    chk("F2_rd",     cap_rd,   5'd9);
    chk("F2_data",   cap_data, 32'h1234);

    // Flush while idle: the instruction is not accepted.
    run_op(0, 5'd6, -1, 32'h0, 0, 0, -1, 4);
    chk("G_pulses",  st_cm,         0);
    chk("G_busy",    busy_hist[1],  1'b0);
    chk("G_stall",   stall_hist[0], 1'b0);

    // Div with ready only in START: ignored, so it times out.
    run_op(1, 5'd4, 1, 32'h77, 0, -1, -1, 68);
    chk("H_done_k",  done_k,   65);
    chk("H_rd",      cap_rd,   5'd30);
    chk("H_data",    cap_data, 32'd5);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_controller.md
MULTDIV_CONTROLLER -- requirements
Module: multdiv_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock (posedge) and reset.
REQ-002 SHALL have parameter TIMEOUT, default 63, the maximum number of WAIT cycles before forced completion.
REQ-003 clock  in  1  system clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 dx_op  in  5  opcode of the instruction in the DX stage.
REQ-006 dx_aluop  in  5  ALU opcode field of the DX instruction.
REQ-007 dx_rd  in  5  destination register of the DX instruction.
REQ-008 flush  in  1  pipeline flush; aborts any operation in flight.
REQ-009 md_result  in  32  result from the multdiv unit.
REQ-010 md_ready  in  1  multdiv result-ready strobe.
REQ-011 md_ovf  in  1  multdiv overflow or divide-by-zero flag, valid with md_ready.
REQ-012 ctrl_MULT  out  1  one-cycle multiply start pulse.
REQ-013 ctrl_DIV  out  1  one-cycle divide start pulse.
REQ-014 stall  out  1  freezes the FD and DX stages.
REQ-015 busy  out  1  high when state is not IDLE.
REQ-016 wb_valid  out  1  one-cycle register-file write enable.
REQ-017 wb_rd  out  5  write-back register.
REQ-018 wb_data  out  32  write-back data.
REQ-019 md_exc  out  1  one-cycle exception strobe, coincident with wb_valid.

Function
REQ-020 SHALL decode is_mult as dx_op=00000 and dx_aluop=00110, and is_div as dx_op=00000 and dx_aluop=00111; is_md = is_mult | is_div.
REQ-021 SHALL implement a four-state FSM: IDLE, START, WAIT, DONE.
REQ-022 IDLE, with is_md=1 and flush=0: SHALL latch dx_rd and kind (mult or div), then go to START.
REQ-023 IDLE, with flush=1 or is_md=0: SHALL remain in IDLE.
REQ-024 START: SHALL drive exactly one of ctrl_MULT or ctrl_DIV per the latched kind, clear the cycle counter, and go to WAIT; md_ready SHALL be ignored in START.
REQ-025 WAIT: SHALL increment the 6-bit cycle counter each cycle.
REQ-026 WAIT, with md_ready=1: SHALL latch md_result and md_ovf, then go to DONE.
REQ-027 WAIT timeout: when the counter reaches TIMEOUT without md_ready, SHALL go to DONE with the latched overflow forced to 1.
REQ-028 WAIT, with flush=1: SHALL go to IDLE with no write-back; flush SHALL take priority over a simultaneous md_ready or timeout.
REQ-029 DONE: SHALL assert wb_valid for exactly one cycle, then go to IDLE unconditionally; flush in DONE SHALL NOT suppress the write-back.
REQ-030 DONE write-back without overflow: wb_rd = latched rd and wb_data = latched result.
REQ-031 DONE with latched rd=0 and no overflow: wb_valid SHALL be 0.
REQ-032 DONE with overflow: wb_rd=30, wb_data=32'd4 for mult or 32'd5 for div, and md_exc=1.
REQ-033 stall SHALL equal (IDLE & is_md & ~flush) | START | WAIT, and SHALL be 0 in DONE so that the DX instruction retires.
REQ-034 ctrl_MULT, ctrl_DIV, busy, wb_valid and md_exc SHALL be decoded from the registered state only; stall is the only output with a combinational input path.
REQ-035 Outside DONE, wb_valid and md_exc SHALL be 0, and wb_rd and wb_data SHALL hold their last values.
REQ-036 No new operation SHALL be accepted while busy=1.

Reset
REQ-037 On reset=1 at a clock edge, SHALL force state IDLE, counter 0, and latched rd, kind, result and overflow all 0.
REQ-038 After reset, SHALL drive ctrl_MULT, ctrl_DIV, busy, wb_valid, md_exc = 0; wb_rd=0; wb_data=0.
REQ-039 stall after reset SHALL be 0 unless IDLE & is_md & ~flush holds.
REQ-040 Reset mid-operation (START, WAIT or DONE) SHALL abort with no write-back and no ctrl pulse in the following cycle.

Verification
REQ-041 Mult, normal: dx aluop=00110, rd=5; md_ready 4 cycles after ctrl_MULT with result=0x0000_0042, ovf=0 -> exactly one ctrl_MULT pulse, stall high until DONE, wb_valid=1, wb_rd=5, wb_data=0x42.
REQ-042 Div overflow: aluop=00111, rd=7, md_ready with ovf=1 -> wb_rd=30, wb_data=5, md_exc=1, no write to r7.
REQ-043 Flush vs ready: flush and md_ready asserted in the same WAIT cycle -> state IDLE next cycle, wb_valid never asserted.
REQ-044 Timeout: mult issued, md_ready held 0 -> DONE after 63 WAIT cycles; wb_rd=30, wb_data=4, md_exc=1.
REQ-045 rd=0: mult with rd=0, ovf=0 -> wb_valid=0 in DONE, FSM returns to IDLE.
REQ-046 Reset in WAIT: reset pulsed in the 2nd WAIT cycle -> next cycle busy=0, stall=0 (dx not mult/div), no wb_valid; a subsequent mult completes normally.
